// File: rtl/reg_bank_if.sv
// Write/read bus of the register bank: one byte-enabled write port, two read ports.
interface reg_bank_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
);
    localparam int unsigned NBYTES = DATA_WIDTH / 8;

    logic                  write;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [NBYTES-1:0]     wr_byte_en;
    logic [ADDR_WIDTH-1:0] rd_addr_a;
    logic [DATA_WIDTH-1:0] rd_data_a;
    logic [ADDR_WIDTH-1:0] rd_addr_b;
    logic [DATA_WIDTH-1:0] rd_data_b;

    modport master (
        output write, wr_addr, wr_data, wr_byte_en, rd_addr_a, rd_addr_b,
        input  rd_data_a, rd_data_b
    );

    modport slave (
        input  write, wr_addr, wr_data, wr_byte_en, rd_addr_a, rd_addr_b,
        output rd_data_a, rd_data_b
    );
endinterface

// File: rtl/reg_bank.sv
// Multi-entry register bank: byte-enabled write port, two independent read ports,
// optional hardwired zero entry, write-to-read bypass and registered reads.
module reg_bank #(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned ADDR_WIDTH      = 5,
    parameter bit          ZERO_REG        = 1'b1,
    parameter bit          BYPASS          = 1'b1,
    parameter bit          REGISTERED_READ = 1'b0
) (
    input  logic          clk,
    input  logic          reset,
    reg_bank_if.slave     bus
);
    localparam int unsigned DEPTH  = 2 ** ADDR_WIDTH;
    localparam int unsigned NBYTES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] merged_c;
    logic                  wr_zero_c;
    logic                  wr_en_c;
    logic [DATA_WIDTH-1:0] rd_a_c;
    logic [DATA_WIDTH-1:0] rd_b_c;

    // Post-write word: old entry with enabled bytes replaced.
    always_comb begin
        merged_c = mem[bus.wr_addr];
        for (int unsigned i = 0; i < NBYTES; i++) begin
            if (bus.wr_byte_en[i]) begin
                merged_c[8*i +: 8] = bus.wr_data[8*i +: 8];
            end
        end
    end

    // Writes to the hardwired zero entry are dropped, so they never bypass either.
    always_comb begin
        wr_zero_c = ZERO_REG && (bus.wr_addr == '0);
        wr_en_c   = bus.write && !reset && !wr_zero_c;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en_c) begin
            mem[bus.wr_addr] <= merged_c;
        end
    end

    always_comb begin
        rd_a_c = mem[bus.rd_addr_a];
        if (ZERO_REG && (bus.rd_addr_a == '0)) begin
            rd_a_c = '0;
        end else if (BYPASS && wr_en_c && (bus.rd_addr_a == bus.wr_addr)) begin
            rd_a_c = merged_c;
        end
    end

    always_comb begin
        rd_b_c = mem[bus.rd_addr_b];
        if (ZERO_REG && (bus.rd_addr_b == '0)) begin
            rd_b_c = '0;
        end else if (BYPASS && wr_en_c && (bus.rd_addr_b == bus.wr_addr)) begin
            rd_b_c = merged_c;
        end
    end

    generate
        if (REGISTERED_READ) begin : g_rd_reg
            logic [DATA_WIDTH-1:0] rd_a_q;
            logic [DATA_WIDTH-1:0] rd_b_q;

            always_ff @(posedge clk) begin
                if (reset) begin
                    rd_a_q <= '0;
                    rd_b_q <= '0;
                end else begin
                    rd_a_q <= rd_a_c;
                    rd_b_q <= rd_b_c;
                end
            end

            assign bus.rd_data_a = rd_a_q;
            assign bus.rd_data_b = rd_b_q;
        end else begin : g_rd_comb
            assign bus.rd_data_a = rd_a_c;
            assign bus.rd_data_b = rd_b_c;
        end
    endgenerate
endmodule

// File: tb/tb_reg_bank.sv
// Bench for reg_bank: four configurations share one stimulus stream and are checked
// every cycle against an array-based model, plus hand-computed literal expectations.
module tb_reg_bank;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned NCFG = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          write;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [3:0]    wr_be;
    logic [AW-1:0] rd_addr_a;
    logic [AW-1:0] rd_addr_b;
    logic [DW-1:0] rd_a [NCFG];
    logic [DW-1:0] rd_b [NCFG];

    int checks = 0;
    int errors = 0;

    // Model state
    logic [DW-1:0] mem_m [NCFG][32];
    logic [DW-1:0] exp_reg_a [NCFG];
    logic [DW-1:0] exp_reg_b [NCFG];
    bit            reset_seen = 1'b0;

    always #5 clk = ~clk;

    // cfg0: zero+bypass comb, cfg1: plain comb, cfg2: zero+bypass registered, cfg3: plain registered
    for (genvar g = 0; g < NCFG; g++) begin : cfg
        localparam bit ZR = (g == 0) || (g == 2);
        localparam bit RR = (g >= 2);

        reg_bank_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

        assign bus.write      = write;
        assign bus.wr_addr    = wr_addr;
        assign bus.wr_data    = wr_data;
        assign bus.wr_byte_en = wr_be;
        assign bus.rd_addr_a  = rd_addr_a;
        assign bus.rd_addr_b  = rd_addr_b;
        assign rd_a[g]        = bus.rd_data_a;
        assign rd_b[g]        = bus.rd_data_b;

        reg_bank #(
            .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
            .ZERO_REG(ZR), .BYPASS(ZR), .REGISTERED_READ(RR)
        ) dut (
            .clk(clk),
            .reset(reset),
            .bus(bus.slave)
        );
    end

    function automatic bit cfg_zr(int g);
        return (g == 0) || (g == 2);
    endfunction

    function automatic bit cfg_rr(int g);
        return g >= 2;
    endfunction

    function automatic logic [DW-1:0] merge(logic [DW-1:0] old, logic [DW-1:0] d, logic [3:0] be);
        logic [DW-1:0] r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    // What a read of addr must return this cycle under configuration g
    function automatic logic [DW-1:0] model_read(int g, logic [AW-1:0] addr);
        bit zr = cfg_zr(g);
        if (zr && addr == 0) return '0;
        if (zr && write && !reset && addr == wr_addr)
            return merge(mem_m[g][addr], wr_data, wr_be);
        return mem_m[g][addr];
    endfunction

    task automatic check(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        for (int g = 0; g < NCFG; g++) begin
            if (reset) begin
                for (int a = 0; a < 32; a++) mem_m[g][a] = '0;
                exp_reg_a[g] = '0;
                exp_reg_b[g] = '0;
            end else begin
                exp_reg_a[g] = model_read(g, rd_addr_a);
                exp_reg_b[g] = model_read(g, rd_addr_b);
                if (write && !(cfg_zr(g) && wr_addr == 0))
                    mem_m[g][wr_addr] = merge(mem_m[g][wr_addr], wr_data, wr_be);
            end
        end
        if (reset) reset_seen = 1'b1;
    end

    always @(negedge clk) begin
        if (reset_seen) begin
            for (int g = 0; g < NCFG; g++) begin
                check($sformatf("cfg%0d_rd_a", g), rd_a[g],
                      cfg_rr(g) ? exp_reg_a[g] : model_read(g, rd_addr_a));
                check($sformatf("cfg%0d_rd_b", g), rd_b[g],
                      cfg_rr(g) ? exp_reg_b[g] : model_read(g, rd_addr_b));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic drive_wr(logic w, logic [AW-1:0] a, logic [DW-1:0] d, logic [3:0] be);
        write   = w;
        wr_addr = a;
        wr_data = d;
        wr_be   = be;
    endtask

    initial begin
        reset = 1'b1;
        drive_wr(1'b0, '0, '0, '0);
        rd_addr_a = '0;
        rd_addr_b = '0;
        step();
        reset = 1'b0;

        sample();
        check("reg_after_reset_a", rd_a[2], 32'h0);
        check("reg_after_reset_b", rd_b[3], 32'h0);

        // Sweep every address on both ports after reset
        for (int i = 0; i < 32; i++) begin
            rd_addr_a = AW'(i);
            rd_addr_b = AW'(31 - i);
            step();
        end

        // Byte-enabled partial write
        drive_wr(1'b1, 5'd7, 32'hDEADBEEF, 4'b1111);
        step();
        drive_wr(1'b1, 5'd7, 32'h11223344, 4'b0101);
        step();
        drive_wr(1'b0, '0, '0, '0);
        rd_addr_a = 5'd7;
        sample();
        check("byte_merge_comb", rd_a[1], 32'hDE22BE44);
        step();
        sample();
        check("byte_merge_reg", rd_a[2], 32'hDE22BE44);

        // Zero register versus ordinary entry 0
        drive_wr(1'b1, 5'd0, 32'hFFFFFFFF, 4'b1111);
        step();
        drive_wr(1'b0, '0, '0, '0);
        rd_addr_a = 5'd0;
        sample();
        check("zero_reg_a", rd_a[0], 32'h0);
        check("entry0_plain", rd_a[1], 32'hFFFFFFFF);

        // Combinational bypass versus no bypass
        drive_wr(1'b1, 5'd3, 32'hAAAA0000, 4'b1111);
        step();
        drive_wr(1'b1, 5'd3, 32'h12345678, 4'b1111);
        rd_addr_a = 5'd3;
        sample();
        check("bypass_hit", rd_a[0], 32'h12345678);
        check("no_bypass_old", rd_a[1], 32'hAAAA0000);
        step();
        drive_wr(1'b0, '0, '0, '0);
        sample();
        check("no_bypass_after", rd_a[1], 32'h12345678);

        // Registered read latency and registered bypass
        drive_wr(1'b1, 5'd9, 32'h55, 4'b1111);
        step();
        drive_wr(1'b0, '0, '0, '0);
        rd_addr_b = 5'd9;
        step();
        sample();
        check("reg_latency", rd_b[2], 32'h55);
        drive_wr(1'b1, 5'd9, 32'h66, 4'b1111);
        step();
        sample();
        check("reg_bypass", rd_b[2], 32'h66);
        check("reg_no_bypass", rd_b[3], 32'h55);
        drive_wr(1'b0, '0, '0, '0);
        step();
        sample();
        check("reg_no_bypass_after", rd_b[3], 32'h66);

        // Reset beats a same-cycle write
        reset = 1'b1;
        drive_wr(1'b1, 5'd4, 32'h1, 4'b1111);
        rd_addr_a = 5'd4;
        step();
        reset = 1'b0;
        drive_wr(1'b0, '0, '0, '0);
        sample();
        check("reset_beats_write", rd_a[1], 32'h0);
        check("reset_clears_reg", rd_a[3], 32'h0);
        step();

        // Random traffic with occasional reset; model checks every cycle
        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 39) == 0);
            drive_wr(1'($urandom_range(0, 1)), AW'($urandom), $urandom, 4'($urandom));
            if ($urandom_range(0, 2) == 0) wr_addr = AW'($urandom_range(0, 3));
            rd_addr_a = ($urandom_range(0, 1) == 0) ? wr_addr : AW'($urandom);
            rd_addr_b = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom);
            step();
        end
        reset = 1'b0;

        // Back-to-back write burst cut off by reset
        for (int n = 0; n < 7; n++) begin
            drive_wr(1'b1, AW'(n * 5 + 1), $urandom | 32'h1, 4'b1111);
            reset = (n == 6);
            step();
        end
        reset = 1'b0;
        drive_wr(1'b0, '0, '0, '0);
        for (int i = 0; i < 32; i++) begin
            rd_addr_a = AW'(i);
            rd_addr_b = AW'(i);
            sample();
            check($sformatf("burst_reset_addr%0d", i), rd_a[1], 32'h0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
